// File: rtl/result_drain_serializer.sv
// result_drain_serializer
//
// Captures one vector of ROW_WIDTH signed column sums from the adder-tree
// array, requantizes each sum to DATA_WIDTH (round half up, arithmetic
// shift right by SHIFT, saturate), and streams the elements out one per
// cycle, element 0 first. The accepted beats that saturated are counted for debug.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   in_result    ROW_WIDTH packed signed sums, element k at [OUT_WIDTH*k +: OUT_WIDTH]
//   in_valid     upstream presents in_result
//   in_ready     vector accepted this cycle (IDLE, or last beat being accepted)
//   out_data     quantized signed element
//   out_idx      element index of out_data
//   out_last     beat carries element ROW_WIDTH-1
//   out_valid    out_data valid
//   out_ready    downstream accepts the beat
//   sat_count    saturated accepted beats, sticks at all-ones
//   clear_stats  synchronous clear of sat_count (wins over increment)
module result_drain_serializer #(
  parameter int ROW_WIDTH  = 10,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 36,
  parameter int SHIFT      = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(ROW_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ROW_WIDTH*OUT_WIDTH-1:0] in_result,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_WIDTH-1:0]           sat_count,
  input  logic                           clear_stats
);

  typedef enum logic {IDLE, DRAIN} state_t;

  // Requantization constants, all OUT_WIDTH+1 bits signed so the rounded
  // sum of the largest input cannot overflow.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [OUT_WIDTH:0] RND =
    (SHIFT > 0) ? ((OUT_WIDTH+1)'(1) << RND_SH) : '0;
  localparam logic signed [OUT_WIDTH:0] MAX_V =
    {{(OUT_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH:0] MIN_V =
    {{(OUT_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [OUT_WIDTH-1:0]  cap_q [ROW_WIDTH];
  logic                         last_idx;
  logic                         capture;
  logic                         beat;

  assign last_idx = (idx_q == IDX_W'(ROW_WIDTH - 1));
  assign capture  = in_valid & in_ready;
  assign beat     = out_valid & out_ready;

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        // Accepting a new vector while the last beat leaves keeps the
        // stream gap-free; this is the only input-to-output comb path.
        in_ready  = last_idx & out_ready;
        if (out_ready) begin
          if (last_idx) begin
            idx_d = '0;
            if (!in_valid) state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the capture buffer is reset on purpose: out_data is decoded
      // from it, and it must read 0 out of reset.
      for (int k = 0; k < ROW_WIDTH; k++) cap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        for (int k = 0; k < ROW_WIDTH; k++)
          cap_q[k] <= in_result[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Requantize the selected element: sign-extend, round, shift, saturate.
  logic signed [OUT_WIDTH-1:0] sel;
  logic signed [OUT_WIDTH:0]   ext;
  logic signed [OUT_WIDTH:0]   rounded;
  logic signed [OUT_WIDTH:0]   shifted;
  logic                        sat_hi, sat_lo, q_sat;

  assign sel     = cap_q[idx_q];
  assign ext     = {sel[OUT_WIDTH-1], sel};
  assign rounded = ext + RND;
  assign shifted = rounded >>> SHIFT;
  assign sat_hi  = (shifted > MAX_V);
  assign sat_lo  = (shifted < MIN_V);
  assign q_sat   = sat_hi | sat_lo;

  assign out_data = sat_hi ? MAX_V[DATA_WIDTH-1:0] :
                    sat_lo ? MIN_V[DATA_WIDTH-1:0] :
                             shifted[DATA_WIDTH-1:0];
  assign out_idx  = idx_q;
  assign out_last = (state_q == DRAIN) & last_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (clear_stats) begin
      sat_count <= '0;
    end else if (beat && q_sat && !(&sat_count)) begin
      sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule
